idct_befifft_framer: RTL and testbench
======================================

Name: idct_befifft_framer

Overview:
- Input-side counterpart of the post-IFFT scaling stage.
- Accepts a continuous stream of 16-bit complex samples from the IDCT pre-processing and pre-scales them into the IFFT input width.
- Frames them into packets of fftpts samples with sop/eop, and drives the IFFT sink interface with full ready/valid backpressure.
- Sits immediately upstream of the IFFT core.

Parameters:
- wDataIn, 16, sample width on the input side (two's complement).
- wDataOut, 28, IFFT input width. Must be at least wDataIn+8.
- wPts, 12, width of the frame-length fields.

Ports:
- clk  input  1  clock.
- rst_sync  input  1  synchronous reset, active-high.
- sink_valid  input  1  input sample valid.
- sink_ready  output  1  input may be accepted this cycle.
- sink_sop  input  1  optional frame-start marker from upstream.
- sink_real  input  wDataIn  input real part.
- sink_imag  input  wDataIn  input imaginary part.
- fftpts_cfg  input  wPts  requested frame length; sampled at frame start.
- source_valid  output  1  IFFT sink valid.
- source_ready  input  1  IFFT sink ready.
- source_sop  output  1  first sample of frame.
- source_eop  output  1  last sample of frame.
- source_error  output  2  00 normal; 01 on the sop beat of a frame started by resync.
- source_real  output  wDataOut  scaled real part.
- source_imag  output  wDataOut  scaled imaginary part.
- fftpts_out  output  wPts  frame length latched for the current output frame.
- sync_err  output  1  one-cycle pulse on resync.

Behaviour:
- Reset (rst_sync=1 at a clk edge):
  - source_valid, source_sop, source_eop, sync_err = 0; source_error = 00.
  - source_real, source_imag = 0; fftpts_out = 2048.
  - Skid buffer emptied, frame counter = 0, sink_ready = 0.
  - sink_ready rises the cycle after reset deasserts.
  - Reset mid-frame discards all buffered and partial data; the next accepted sample starts a new frame.
- Handshake:
  - An input beat is accepted when sink_valid & sink_ready.
  - An output beat is transferred when source_valid & source_ready.
  - sink_ready is registered: sink_ready = !(buffer holds 2 entries).
  - Internal 2-entry skid buffer. Zero bubbles at full throughput.
  - Latency from input accept to source_valid is 1 cycle when the buffer is empty.
  - source_* payload is held stable while source_valid=1 and source_ready=0.
- Frame counter:
  - cnt counts accepted beats, 0..pts-1.
  - When cnt==0: pts <= fftpts_cfg; a value of 0 is mapped to 2048.
  - Beat at cnt==0 is tagged sop; beat at cnt==pts-1 is tagged eop, and cnt wraps to 0.
  - pts==1: sop and eop are tagged on the same beat.
  - fftpts_cfg changes mid-frame are ignored until the next frame.
- Resync:
  - Triggered when sink_sop=1 is accepted with cnt!=0.
  - The partial frame ends with no eop.
  - The beat is tagged sop with error 01; cnt <= 1 and pts is re-latched.
  - sync_err pulses for 1 cycle on the cycle after the accept.
  - sink_sop with cnt==0 is a normal frame start.
- Scaling (sign-extend, then shift left):
  - pts==512: shift by 7.
  - All other pts: shift by 8.
  - No rounding or saturation is needed because of the width rule.
  - The tags (sop/eop/error/pts) travel with the data through the skid buffer.
- Simultaneous accept and transfer in the same cycle: buffer occupancy is unchanged and ordering is strictly FIFO.

Decomposition:
- Shared package idct_pkg:
  - PTS_DEFAULT=2048 and PTS_512=512.
  - SHIFT_DEFAULT=8 and SHIFT_512=7.
  - Error codes ERR_NONE=2'b00 and ERR_RESYNC=2'b01.
- One sub-module: idct_skid_buf2, a parameterised-width 2-entry ready/valid skid buffer. The payload is {sop, eop, error, pts, real, imag}.
- Framing and scaling stay in the top.

Test Plan:
- Reset, then fftpts_cfg=2048, 2048 beats with sink_real=1, sink_imag=-1 and source_ready=1 → source_real=256, source_imag=-256; sop on beat 0; eop on beat 2047; no bubbles; fftpts_out=2048.
- fftpts_cfg=512, sink_real=32767, sink_imag=-32768 → source_real=4194176, source_imag=-4194304; eop on beat 511; next beat is sop.
- Random source_ready stall pattern over 3 frames of 8 (fftpts_cfg=8):
  - payload and order intact;
  - sink_ready drops only when 2 entries are held;
  - payload stable during stalls.
- sink_sop asserted on beat 5 of an 8-point frame → that beat is sop with source_error=01; sync_err pulses once; eop comes 7 beats later.
- fftpts_cfg=1 → every beat has sop=eop=1. fftpts_cfg=0 → frames of 2048.
- rst_sync asserted mid-frame with the buffer full → source_valid=0 the next cycle; after release the first beat carries sop.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared constants for the IDCT-to-IFFT input framer: default frame length,
// scaling shifts and the source_error codes.
package idct_pkg;
  localparam int PTS_DEFAULT   = 2048;
  localparam int PTS_512       = 512;
  localparam int SHIFT_DEFAULT = 8;
  localparam int SHIFT_512     = 7;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_RESYNC = 2'b01;
endpackage

// File: rtl/idct_skid_buf2.sv
// Two-entry ready/valid skid buffer. Head entry drives the output directly;
// up_ready is registered and drops only while both entries are occupied.
module idct_skid_buf2 #(
  parameter int            W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_sync,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);
  logic [W-1:0] mem0, mem1;
  logic [1:0]   cnt, cnt_nxt;
  logic         rdy, push, pop;

  always_comb begin
    push    = up_valid & rdy;
    pop     = (cnt != 2'd0) & dn_ready;
    cnt_nxt = cnt + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      cnt  <= 2'd0;
      rdy  <= 1'b0;
      mem0 <= RST_VAL;
      mem1 <= RST_VAL;
    end else begin
      cnt <= cnt_nxt;
      rdy <= (cnt_nxt != 2'd2);
      // head only moves on pop or when the buffer is empty, so it holds during stalls
      if (pop && cnt == 2'd2)
        mem0 <= mem1;
      else if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop)))
        mem0 <= up_data;
      if (push && cnt == 2'd1 && !pop)
        mem1 <= up_data;
    end
  end

  assign up_ready = rdy;
  assign dn_valid = (cnt != 2'd0);
  assign dn_data  = mem0;
endmodule

// File: rtl/idct_befifft_framer.sv
// Frames a continuous complex sample stream into IFFT packets with sop/eop,
// pre-scales samples to the IFFT input width and handles sop resync.
module idct_befifft_framer
  import idct_pkg::*;
#(
  parameter int wDataIn  = 16,
  parameter int wDataOut = 28,
  parameter int wPts     = 12
) (
  input  logic                clk,
  input  logic                rst_sync,
  input  logic                sink_valid,
  output logic                sink_ready,
  input  logic                sink_sop,
  input  logic [wDataIn-1:0]  sink_real,
  input  logic [wDataIn-1:0]  sink_imag,
  input  logic [wPts-1:0]     fftpts_cfg,
  output logic                source_valid,
  input  logic                source_ready,
  output logic                source_sop,
  output logic                source_eop,
  output logic [1:0]          source_error,
  output logic [wDataOut-1:0] source_real,
  output logic [wDataOut-1:0] source_imag,
  output logic [wPts-1:0]     fftpts_out,
  output logic                sync_err
);
  localparam int PW = 4 + wPts + 2*wDataOut;
  localparam logic [PW-1:0] RST_PAY = {4'b0, wPts'(PTS_DEFAULT), {(2*wDataOut){1'b0}}};

  logic [wPts-1:0]     cnt, pts, cfg_m, pts_cur, pos;
  logic                acc, start, resync, eop;
  logic [3:0]          shamt;
  logic [wDataOut-1:0] re_s, im_s;
  logic [PW-1:0]       pay_in, pay_out;

  always_comb begin
    acc     = sink_valid & sink_ready;
    cfg_m   = (fftpts_cfg == '0) ? wPts'(PTS_DEFAULT) : fftpts_cfg;
    start   = (cnt == '0) | sink_sop;
    resync  = sink_sop & (cnt != '0);
    // a new frame (normal or resync) uses the freshly sampled length for its own beat
    pts_cur = start ? cfg_m : pts;
    pos     = start ? '0 : cnt;
    eop     = (pos == pts_cur - 1'b1);
    shamt   = (pts_cur == wPts'(PTS_512)) ? 4'(SHIFT_512) : 4'(SHIFT_DEFAULT);
    re_s    = {{(wDataOut-wDataIn){sink_real[wDataIn-1]}}, sink_real} << shamt;
    im_s    = {{(wDataOut-wDataIn){sink_imag[wDataIn-1]}}, sink_imag} << shamt;
    pay_in  = {start, eop, (resync ? ERR_RESYNC : ERR_NONE), pts_cur, re_s, im_s};
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      cnt      <= '0;
      pts      <= wPts'(PTS_DEFAULT);
      sync_err <= 1'b0;
    end else begin
      sync_err <= acc & resync;
      if (acc) begin
        pts <= pts_cur;
        cnt <= eop ? '0 : pos + 1'b1;
      end
    end
  end

  idct_skid_buf2 #(.W(PW), .RST_VAL(RST_PAY)) u_skid (
    .clk      (clk),
    .rst_sync (rst_sync),
    .up_valid (sink_valid),
    .up_ready (sink_ready),
    .up_data  (pay_in),
    .dn_valid (source_valid),
    .dn_ready (source_ready),
    .dn_data  (pay_out)
  );

  assign {source_sop, source_eop, source_error, fftpts_out, source_real, source_imag} = pay_out;
endmodule

// File: tb/tb_idct_befifft_framer.sv
// Randomized bench for idct_befifft_framer with a frame-level reference model
// and an expected-beat queue compared on every cycle a beat is presented.
module tb_idct_befifft_framer;
  logic        clk = 1'b0;
  logic        rst_sync = 1'b1;
  logic        sink_valid = 1'b0, sink_ready, sink_sop = 1'b0;
  logic [15:0] sink_real = '0, sink_imag = '0;
  logic [11:0] fftpts_cfg = 12'd2048;
  logic        source_valid, source_ready, source_sop, source_eop, sync_err;
  logic [1:0]  source_error;
  logic [27:0] source_real, source_imag;
  logic [11:0] fftpts_out;

  idct_befifft_framer dut (
    .clk(clk), .rst_sync(rst_sync),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop),
    .sink_real(sink_real), .sink_imag(sink_imag), .fftpts_cfg(fftpts_cfg),
    .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop), .source_error(source_error),
    .source_real(source_real), .source_imag(source_imag),
    .fftpts_out(fftpts_out), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sop, eop;
    logic [1:0]  err;
    logic [11:0] pts;
    logic [27:0] re, im;
  } beat_t;

  int    n_vec = 0, n_bad = 0;
  beat_t q[$];
  int    occ = 0, pos = 0, flen = 2048;
  bit    sync_exp = 0, rst_q1 = 1, mon_en = 0;
  int    rdy_mode = 1;  // 0: stall, 1: always ready, 2: random

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    rst_q1 = rst_sync;
    #1;
    case (rdy_mode)
      0:       source_ready = 1'b0;
      1:       source_ready = 1'b1;
      default: source_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic logic [27:0] scale(input logic [15:0] v, input int sh);
    longint x;
    x = longint'($signed(v));
    x = x <<< sh;
    return x[27:0];
  endfunction

  // Reference: frame position and length tracked per accepted sample.
  always @(negedge clk) begin
    if (mon_en) begin
      bit acc, xfer, rs;
      beat_t b;
      chk("sink_ready", 64'(sink_ready), 64'(!rst_q1 && occ != 2));
      chk("source_valid", 64'(source_valid), 64'(occ != 0));
      chk("sync_err", 64'(sync_err), 64'(sync_exp));
      if (source_valid && q.size() > 0) begin
        chk("data", {8'b0, source_real, source_imag}, {8'b0, q[0].re, q[0].im});
        chk("tags", {48'b0, source_sop, source_eop, source_error, fftpts_out},
                    {48'b0, q[0].sop, q[0].eop, q[0].err, q[0].pts});
      end
      if (rst_sync) begin
        q.delete(); occ = 0; pos = 0; flen = 2048; sync_exp = 0;
      end else begin
        acc  = sink_valid && sink_ready;
        xfer = source_valid && source_ready;
        if (xfer && q.size() > 0) void'(q.pop_front());
        sync_exp = 0;
        if (acc) begin
          rs = sink_sop && pos != 0;
          if (pos == 0 || sink_sop) begin
            flen = (fftpts_cfg == 0) ? 2048 : int'(fftpts_cfg);
            pos  = 0;
          end
          b.sop = (pos == 0);
          b.eop = (pos == flen - 1);
          b.err = rs ? 2'b01 : 2'b00;
          b.pts = 12'(flen);
          b.re  = scale(sink_real, flen == 512 ? 7 : 8);
          b.im  = scale(sink_imag, flen == 512 ? 7 : 8);
          q.push_back(b);
          pos = b.eop ? 0 : pos + 1;
          sync_exp = rs;
        end
        occ = occ + int'(acc) - int'(xfer);
      end
    end
  end

  task automatic send(input logic [15:0] r, input logic [15:0] i, input logic s);
    bit done = 0;
    sink_valid = 1'b1; sink_real = r; sink_imag = i; sink_sop = s;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      done = sink_ready;
      @(posedge clk); #1;
    end
    sink_valid = 1'b0; sink_sop = 1'b0;
    chk("accept", 64'(done), 64'd1);
  endtask

  task automatic send_rand(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      send(16'($urandom), 16'($urandom), 1'b0);
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(source_valid), 64'd0);
    chk("rst_ready", 64'(sink_ready), 64'd0);
    chk("rst_tags", {48'b0, source_sop, source_eop, source_error, fftpts_out}, 64'd2048);
    chk("rst_data", {8'b0, source_real, source_imag}, 64'd0);
    chk("rst_sync_err", 64'(sync_err), 64'd0);
    mon_en = 1;
    @(posedge clk); #1;
    rst_sync = 1'b0;

    // 2048-point frame, unit samples, full throughput
    fftpts_cfg = 12'd2048;
    for (int k = 0; k < 2048; k++) send(16'd1, 16'hFFFF, 1'b0);
    // two 512-point frames at full scale
    fftpts_cfg = 12'd512;
    for (int k = 0; k < 1024; k++) send(16'sd32767, 16'h8000, 1'b0);

    // 8-point frames under random backpressure and input gaps
    fftpts_cfg = 12'd8;
    rdy_mode = 2;
    send_rand(24, 1'b1);

    // resync on beat 5, then the full 8-beat frame it starts
    send_rand(5, 1'b0);
    send(16'($urandom), 16'($urandom), 1'b1);
    send_rand(7, 1'b1);

    fftpts_cfg = 12'd1;
    send_rand(4, 1'b1);
    rdy_mode = 1;
    fftpts_cfg = 12'd0;
    send_rand(2050, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    fftpts_cfg = 12'd8;
    send_rand(2046, 1'b0);  // finish the open 2048-point frame

    // fill the buffer under stall, then reset mid-frame
    rdy_mode = 0;
    send_rand(2, 1'b0);
    rst_sync = 1'b1;
    @(posedge clk); #1;
    rst_sync = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(source_valid), 64'd0);
    rdy_mode = 1;
    @(posedge clk); #1;
    send_rand(8, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
